// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEF = 8;

    // Sequencer states: fetching, waiting out memory latency, stopped on double fault.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } state_e;

    // Where the next fetch address comes from.
    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        TRAP = 3'd3,
        ERET = 3'd4
    } pc_src_e;

    // Per-instruction control flags coming from decode and the ALU.
    typedef struct packed {
        logic take_branch;
        logic ovf;
        logic ovf_en;
        logic jump;
        logic eret;
    } flags_t;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer_pc_next_mux.sv
// Priority selection of the next fetch address and the redirect/halt decision.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned      PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0]  TRAP_VECTOR = PC_W'(8'hF0)
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] epc_i,
    input  logic            in_handler_i,
    input  flags_t          flags_i,
    input  logic [PC_W-1:0] branch_offset_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic [PC_W-1:0] next_pc_c,
    output pc_src_e         src_c,
    output logic            redirect_c,
    output logic            halt_c
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] eret_pc;

    // Candidate addresses; offset already has PC_W bits so sign extension is implicit in the wrap.
    always_comb begin
        seq_pc  = PC_W'(pc_i + PC_W'(1));
        br_pc   = PC_W'(seq_pc + branch_offset_i);
        eret_pc = PC_W'(epc_i + PC_W'(1));
    end

    // Highest-priority event wins; a trap inside the handler is a double fault.
    always_comb begin
        src_c  = SEQ;
        halt_c = 1'b0;
        if (flags_i.ovf && flags_i.ovf_en && in_handler_i) begin
            halt_c = 1'b1;
        end else if (flags_i.ovf && flags_i.ovf_en) begin
            src_c = TRAP;
        end else if (flags_i.eret && in_handler_i) begin
            src_c = ERET;
        end else if (flags_i.eret) begin
            src_c = SEQ;
        end else if (flags_i.jump) begin
            src_c = JMP;
        end else if (flags_i.take_branch) begin
            src_c = BR;
        end else begin
            src_c = SEQ;
        end
    end

    // Address mux; a halting instruction leaves pc where it is.
    always_comb begin
        next_pc_c = seq_pc;
        if (halt_c) begin
            next_pc_c = pc_i;
        end else begin
            case (src_c)
                SEQ:     next_pc_c = seq_pc;
                BR:      next_pc_c = br_pc;
                JMP:     next_pc_c = jump_target_i;
                TRAP:    next_pc_c = TRAP_VECTOR;
                ERET:    next_pc_c = eret_pc;
                default: next_pc_c = seq_pc;
            endcase
        end
        redirect_c = !halt_c && (src_c != SEQ);
    end

endmodule : pc_next_mux

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-pc selection, redirect bubble and exception state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned      PC_W         = PC_W_DEF,
    parameter logic [PC_W-1:0]  RESET_VECTOR = PC_W'(8'h00),
    parameter logic [PC_W-1:0]  TRAP_VECTOR  = PC_W'(8'hF0)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            take_branch,
    input  logic            ovf,
    input  logic            ovf_en,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            eret,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic [PC_W-1:0] epc,
    output logic            in_handler,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            in_handler_q, in_handler_d;
    logic            instr_valid_q, instr_valid_d;
    logic            halted_q, halted_d;

    flags_t          flags;
    logic [PC_W-1:0] next_pc_c;
    pc_src_e         src_c;
    logic            redirect_c;
    logic            halt_c;

    assign flags = '{take_branch: take_branch, ovf: ovf, ovf_en: ovf_en,
                     jump: jump, eret: eret};

    pc_next_mux #(
        .PC_W        (PC_W),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_mux (
        .pc_i            (pc_q),
        .epc_i           (epc_q),
        .in_handler_i    (in_handler_q),
        .flags_i         (flags),
        .branch_offset_i (branch_offset),
        .jump_target_i   (jump_target),
        .next_pc_c       (next_pc_c),
        .src_c           (src_c),
        .redirect_c      (redirect_c),
        .halt_c          (halt_c)
    );

    // State and datapath registers; reset overrides stall and everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            in_handler_q  <= 1'b0;
            instr_valid_q <= 1'b1;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            in_handler_q  <= in_handler_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // Next state: flags only matter in RUN, a bubble lasts one unstalled cycle, HALT is sticky.
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (halt_c) begin
                        state_d = HALT;
                    end else if (redirect_c) begin
                        state_d = BUBBLE;
                    end
                end
                BUBBLE:  state_d = RUN;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    // Datapath updates happen only on an unstalled RUN cycle that does not halt.
    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        in_handler_d  = in_handler_q;
        if (!stall && (state_q == RUN) && !halt_c) begin
            pc_d = next_pc_c;
            if (src_c == TRAP) begin
                epc_d        = pc_q;
                in_handler_d = 1'b1;
            end else if (src_c == ERET) begin
                in_handler_d = 1'b0;
            end
        end
        instr_valid_d = (state_d == RUN);
        halted_d      = (state_d == HALT);
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign in_handler  = in_handler_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule : pc_sequencer
